bias_accum_stage: RTL and testbench
===================================

# bias_accum_stage

Per-lane accumulate-and-bias stage sitting directly after the convolution adder trees. It consumes N_adder_tree signed 18-bit partial sums per beat over one or more input-channel passes. The per-lane bias vector from the layer's bias bank is added once, at the start of each output group. It emits one saturated, optionally ReLU-clamped, 18-bit result per lane through a valid/ready handshake.

## Interface
- N_adder_tree, 16, number of parallel lanes.
- W, 18, lane width; signed two's complement, same fixed-point format as the bias bank.
- RELU, 1, 1 = clamp negative results to 0 on output; 0 = pass through.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- bias  input  N_adder_tree*W  per-lane bias; lane i at [W*(i+1)-1:W*i]; static during a group.
- in_valid  input  1  partial-sum beat present.
- in_ready  output  1  stage can accept a beat.
- in_data  input  N_adder_tree*W  per-lane partial sums, same lane packing as bias.
- in_last  input  1  qualifies the current beat as the final pass of the group.
- out_valid  output  1  result vector valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  N_adder_tree*W  per-lane results, same lane packing.
- out_sat  output  1  at least one lane saturated at some point during the group.
- out_passes  output  8  number of beats accumulated in the group; saturates at 255.

## Operation
- States: IDLE (accumulators empty), ACCUM (group in progress), OUT (result held).
- A beat is accepted when in_valid && in_ready.
- in_ready = 1 in IDLE and ACCUM; 0 in OUT.
- IDLE, beat accepted:
  - Per lane, acc <= sat(bias + in_data).
  - pass_cnt <= 1.
  - sat_flag <= OR of the lane overflows.
  - Next state: OUT if in_last, else ACCUM.
- ACCUM, beat accepted:
  - acc <= sat(acc + in_data).
  - pass_cnt <= min(pass_cnt + 1, 255).
  - sat_flag accumulates (sticky OR).
  - Next state: OUT if in_last, else ACCUM.
- Any state with no beat accepted: accumulators, counter and flag hold.
- Saturating add:
  - Form the sum at W+1 bits.
  - Result above 2^(W-1)-1 clamps to 0x1FFFF (131071).
  - Result below -2^(W-1) clamps to 0x20000 (-131072).
  - Either clamp sets sat_flag.
- Output formation:
  - out_data lane = (RELU && acc < 0) ? 0 : acc.
  - The ReLU clamp does not set out_sat.
- OUT:
  - out_valid = 1.
  - out_data, out_sat and out_passes are stable until out_ready.
  - On out_ready: next state is IDLE; accumulators, pass_cnt and sat_flag clear to 0.
- The bias is sampled only on the IDLE accepting beat. Changes to bias mid-group have no effect.
- in_last in ACCUM while pass_cnt is 255: the counter stays at 255 and the group completes normally.

## Timing
- Reset (rst_n low, asynchronous):
  - State is IDLE.
  - out_valid=0, out_data=0, out_sat=0, out_passes=0.
  - All accumulators are 0.
  - in_ready=1 once out of reset.
- All outputs are registered. in_ready is a decode of the state register, so it has no combinational path from out_ready.
- Latency: out_valid rises on the clock edge that accepts the in_last beat. The result is visible 1 cycle after that beat is presented.
- Handshake: on the out_ready edge in OUT, out_valid falls on that same edge, and in_ready is 1 in the following cycle. There is exactly one bubble cycle between groups.
- Back-pressure: out_ready held low leaves out_* frozen for any number of cycles, and in_ready stays 0.
- Reset asserted mid-group or during OUT: the partial group is discarded. No output is produced for it.
- Throughput: in ACCUM, one beat per cycle with no stalls.

## Test plan
- Single-pass group:
  - Stimulus: bias lane0 = 0x00100 (256), in_data lane0 = 0x00080 (128), in_last=1, out_ready=1.
  - Response: out_data lane0 = 384 one cycle later, out_passes=1, out_sat=0.
- Three-pass accumulate:
  - Stimulus: bias lane3 = -3000; beats lane3 = 1000, 1000, 500 (last).
  - Response: out_data lane3 = 0 with RELU=1, or -500 with RELU=0; out_passes=3; out_sat=0.
- Positive saturation:
  - Stimulus: bias lane15 = 100000; beats lane15 = 20000, 20000 (last).
  - Response: out_data lane15 = 131071, out_sat=1.
  - Other lanes are unaffected.
- Back-pressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid rises, keeping in_valid=1.
  - Response: in_ready=0 and out_* stable for all 5 cycles. After out_ready=1, out_valid falls, and the next group's first beat is accepted the following cycle with the bias re-added.
- Reset mid-group:
  - Stimulus: accept 2 non-last beats, then pulse rst_n low for 1 cycle.
  - Response: out_valid stays 0. The next single last beat with bias=0, in=7 yields out_data=7 and out_passes=1.

Source files
------------

// File: rtl/bias_accum_stage.sv
// Per-lane accumulate-and-bias stage behind the adder trees: adds the bias once per group,
// accumulates partial sums with saturation, and hands the result out over valid/ready.
module bias_accum_stage #(
  parameter int N_adder_tree = 16,
  parameter int W            = 18,
  parameter bit RELU         = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_adder_tree*W-1:0] bias,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_adder_tree*W-1:0] in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_adder_tree*W-1:0] out_data,
  output logic                      out_sat,
  output logic [7:0]                out_passes
);

  localparam int NW = N_adder_tree * W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [NW-1:0]           acc_q;
  logic [NW-1:0]           out_q;
  logic [NW-1:0]           sum_data;
  logic [NW-1:0]           relu_data;
  logic [N_adder_tree-1:0] lane_ovf;
  logic [7:0]              pass_cnt;
  logic                    sat_flag;
  logic                    accept;
  logic                    release_out;
  logic [W-1:0]            base;
  logic [W-1:0]            lane_res;
  logic [W:0]              wide;

  assign in_ready    = (state != S_OUT);
  assign out_valid   = (state == S_OUT);
  assign accept      = in_valid && in_ready;
  assign release_out = (state == S_OUT) && out_ready;

  assign out_data   = out_q;
  assign out_sat    = sat_flag;
  assign out_passes = pass_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_ACCUM: if (accept) state_nxt = in_last ? S_OUT : S_ACCUM;
      S_OUT:           if (out_ready) state_nxt = S_IDLE;
      default:         state_nxt = S_IDLE;
    endcase
  end

  // The first beat of a group starts from the bias instead of the (empty) accumulator.
  always_comb begin
    sum_data  = '0;
    relu_data = '0;
    lane_ovf  = '0;
    base      = '0;
    wide      = '0;
    lane_res  = '0;
    for (int i = 0; i < N_adder_tree; i++) begin
      base = (state == S_IDLE) ? bias[W*i +: W] : acc_q[W*i +: W];
      wide = {base[W-1], base} + {in_data[W*i+W-1], in_data[W*i +: W]};
      lane_ovf[i] = wide[W] ^ wide[W-1];
      if (lane_ovf[i])
        lane_res = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      else
        lane_res = wide[W-1:0];
      sum_data[W*i +: W]  = lane_res;
      relu_data[W*i +: W] = (RELU && lane_res[W-1]) ? '0 : lane_res;
    end
  end

  // The ReLU view is registered alongside the raw accumulator so out_data is a flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      out_q    <= '0;
      pass_cnt <= '0;
      sat_flag <= 1'b0;
    end else if (release_out) begin
      acc_q    <= '0;
      out_q    <= '0;
      pass_cnt <= '0;
      sat_flag <= 1'b0;
    end else if (accept) begin
      acc_q <= sum_data;
      out_q <= relu_data;
      if (state == S_IDLE) begin
        pass_cnt <= 8'd1;
        sat_flag <= |lane_ovf;
      end else begin
        pass_cnt <= (pass_cnt == 8'hFF) ? 8'hFF : pass_cnt + 8'd1;
        sat_flag <= sat_flag | (|lane_ovf);
      end
    end
  end

endmodule

// File: tb/tb_bias_accum_stage.sv
// Self-checking bench for bias_accum_stage: constant vector table, hand-written group
// sequences, and a randomized run against a per-lane integer model.
module tb_bias_accum_stage;

  localparam int N    = 16;
  localparam int W    = 18;
  localparam int NW   = N * W;
  localparam bit RELU = 1'b1;
  localparam int MAXV = 131071;
  localparam int MINV = -131072;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NW-1:0] bias = '0;
  logic [NW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic          out_sat;
  logic [NW-1:0] out_data;
  logic [7:0]    out_passes;

  int errors = 0;
  int checks = 0;

  int m_acc[N];
  bit m_out;
  bit m_started;
  bit m_sat;
  int m_cnt;

  typedef struct {
    int lane;
    int b;
    int d;
    int exp;
    bit exp_sat;
  } vec_t;

  vec_t tbl[6];

  bias_accum_stage #(.N_adder_tree(N), .W(W), .RELU(RELU)) dut (
    .clk(clk), .rst_n(rst_n), .bias(bias), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .out_passes(out_passes)
  );

  always #5 clk = ~clk;

  function automatic logic [NW-1:0] put_lane(input logic [NW-1:0] v, input int lane, input int val);
    logic [NW-1:0] r;
    logic [W-1:0]  lv;
    r  = v;
    lv = val[W-1:0];
    r[W*lane +: W] = lv;
    return r;
  endfunction

  function automatic int get_lane(input logic [NW-1:0] v, input int lane);
    logic [W-1:0] t;
    t = v[W*lane +: W];
    return int'($signed(t));
  endfunction

  function automatic void model_reset();
    foreach (m_acc[i]) m_acc[i] = 0;
    m_out = 0; m_started = 0; m_sat = 0; m_cnt = 0;
  endfunction

  // Whole-group view: integer running sums per lane, clamped to the 18-bit signed range.
  function automatic void model_edge(input bit v, input bit last, input logic [NW-1:0] b,
                                     input logic [NW-1:0] d, input bit ordy);
    int s;
    if (m_out) begin
      if (ordy) model_reset();
      return;
    end
    if (!v) return;
    for (int i = 0; i < N; i++) begin
      s = (m_started ? m_acc[i] : get_lane(b, i)) + get_lane(d, i);
      if (s > MAXV) begin s = MAXV; m_sat = 1; end
      else if (s < MINV) begin s = MINV; m_sat = 1; end
      m_acc[i] = s;
    end
    m_cnt = m_started ? ((m_cnt < 255) ? m_cnt + 1 : 255) : 1;
    m_started = 1;
    if (last) m_out = 1;
  endfunction

  function automatic logic [NW-1:0] model_out();
    logic [NW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r = put_lane(r, i, (RELU && m_acc[i] < 0) ? 0 : m_acc[i]);
    return r;
  endfunction

  task automatic expect_eq(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    expect_eq({tag, ".in_ready"}, NW'(in_ready), NW'(!m_out));
    expect_eq({tag, ".out_valid"}, NW'(out_valid), NW'(m_out));
    if (m_out) begin
      expect_eq({tag, ".out_data"}, out_data, model_out());
      expect_eq({tag, ".out_passes"}, NW'(out_passes), NW'(m_cnt));
      expect_eq({tag, ".out_sat"}, NW'(out_sat), NW'(m_sat));
    end
  endtask

  task automatic applyStimulus(input string tag, input bit v, input bit last,
                               input logic [NW-1:0] b, input logic [NW-1:0] d, input bit ordy);
    in_valid  = v;
    in_last   = last;
    bias      = b;
    in_data   = d;
    out_ready = ordy;
    model_edge(v, last, b, d, ordy);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [NW-1:0] b, d;
    int val;

    tbl[0] = '{lane: 0,  b: 256,     d: 128,   exp: 384,    exp_sat: 0};
    tbl[1] = '{lane: 5,  b: -100,    d: 50,    exp: 0,      exp_sat: 0};
    tbl[2] = '{lane: 15, b: 131071,  d: 1,     exp: 131071, exp_sat: 1};
    tbl[3] = '{lane: 7,  b: -131072, d: -1,    exp: 0,      exp_sat: 1};
    tbl[4] = '{lane: 2,  b: 100000,  d: 31071, exp: 131071, exp_sat: 0};
    tbl[5] = '{lane: 9,  b: -5,      d: 25,    exp: 20,     exp_sat: 0};

    model_reset();
    #12;
    expect_eq("rst.out_valid", NW'(out_valid), '0);
    expect_eq("rst.out_data", out_data, '0);
    expect_eq("rst.out_sat", NW'(out_sat), '0);
    expect_eq("rst.out_passes", NW'(out_passes), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_eq("rst.in_ready", NW'(in_ready), NW'(1));

    for (int k = 0; k < 6; k++) begin
      applyStimulus("tbl_beat", 1, 1, put_lane('0, tbl[k].lane, tbl[k].b),
                    put_lane('0, tbl[k].lane, tbl[k].d), 0);
      expect_eq("tbl_data", out_data, put_lane('0, tbl[k].lane, tbl[k].exp));
      expect_eq("tbl_sat", NW'(out_sat), NW'(tbl[k].exp_sat));
      expect_eq("tbl_passes", NW'(out_passes), NW'(1));
      applyStimulus("tbl_release", 0, 0, '0, '0, 1);
      expect_eq("tbl_valid_fall", NW'(out_valid), '0);
    end

    // Three passes with a mid-group bias change that must be ignored.
    b = put_lane('0, 3, -3000);
    applyStimulus("three_b1", 1, 0, b, put_lane('0, 3, 1000), 0);
    applyStimulus("three_b2", 1, 0, put_lane('0, 3, 5000), put_lane('0, 3, 1000), 0);
    applyStimulus("three_b3", 1, 1, b, put_lane('0, 3, 500), 0);
    expect_eq("three_valid", NW'(out_valid), NW'(1));
    expect_eq("three_data", out_data, '0);
    expect_eq("three_passes", NW'(out_passes), NW'(3));
    expect_eq("three_sat", NW'(out_sat), '0);
    applyStimulus("three_release", 0, 0, '0, '0, 1);

    b = put_lane(put_lane('0, 15, 100000), 0, 10);
    applyStimulus("sat_b1", 1, 0, b, put_lane(put_lane('0, 15, 20000), 0, 1), 0);
    applyStimulus("sat_b2", 1, 1, b, put_lane(put_lane('0, 15, 20000), 0, 2), 0);
    expect_eq("sat_data", out_data, put_lane(put_lane('0, 15, 131071), 0, 13));
    expect_eq("sat_flag", NW'(out_sat), NW'(1));
    expect_eq("sat_passes", NW'(out_passes), NW'(2));
    applyStimulus("sat_release", 0, 0, '0, '0, 1);

    b = put_lane('0, 1, 50);
    applyStimulus("bp_beat", 1, 1, b, put_lane('0, 1, 5), 0);
    expect_eq("bp_valid", NW'(out_valid), NW'(1));
    for (int k = 0; k < 5; k++) begin
      applyStimulus("bp_hold", 1, 0, b, put_lane('0, 1, 99), 0);
      expect_eq("bp_in_ready", NW'(in_ready), '0);
      expect_eq("bp_out_valid", NW'(out_valid), NW'(1));
      expect_eq("bp_out_data", out_data, put_lane('0, 1, 55));
      expect_eq("bp_out_passes", NW'(out_passes), NW'(1));
    end
    applyStimulus("bp_release", 1, 0, b, put_lane('0, 1, 99), 1);
    expect_eq("bp_valid_fall", NW'(out_valid), '0);
    expect_eq("bp_ready_back", NW'(in_ready), NW'(1));
    applyStimulus("bp_next", 1, 1, b, put_lane('0, 1, 7), 0);
    expect_eq("bp_next_data", out_data, put_lane('0, 1, 57));
    expect_eq("bp_next_passes", NW'(out_passes), NW'(1));
    applyStimulus("bp_next_release", 0, 0, '0, '0, 1);

    applyStimulus("mrst_b1", 1, 0, put_lane('0, 0, 40), put_lane('0, 0, 3), 0);
    applyStimulus("mrst_b2", 1, 0, put_lane('0, 0, 40), put_lane('0, 0, 3), 0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    model_reset();
    #1;
    expect_eq("mrst_valid_low", NW'(out_valid), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_eq("mrst_ready", NW'(in_ready), NW'(1));
    applyStimulus("mrst_idle1", 0, 0, '0, '0, 1);
    applyStimulus("mrst_idle2", 0, 0, '0, '0, 1);
    applyStimulus("mrst_beat", 1, 1, '0, put_lane('0, 0, 7), 0);
    expect_eq("mrst_data", out_data, put_lane('0, 0, 7));
    expect_eq("mrst_passes", NW'(out_passes), NW'(1));
    expect_eq("mrst_sat", NW'(out_sat), '0);
    applyStimulus("mrst_release", 0, 0, '0, '0, 1);

    // 300 beats: the pass counter must stick at 255 while the data keeps summing.
    for (int k = 0; k < 299; k++) applyStimulus("cnt_beat", 1, 0, '0, put_lane('0, 0, 1), 0);
    applyStimulus("cnt_last", 1, 1, '0, put_lane('0, 0, 1), 0);
    expect_eq("cnt_passes", NW'(out_passes), NW'(255));
    expect_eq("cnt_data", out_data, put_lane('0, 0, 300));
    applyStimulus("cnt_release", 0, 0, '0, '0, 1);

    for (int k = 0; k < 600; k++) begin
      b = '0;
      d = '0;
      for (int i = 0; i < N; i++) begin
        val = ($urandom_range(2) == 0) ? int'($urandom) : int'($urandom_range(2000)) - 1000;
        b = put_lane(b, i, val);
        val = ($urandom_range(3) == 0) ? int'($urandom) : int'($urandom_range(60000)) - 30000;
        d = put_lane(d, i, val);
      end
      applyStimulus("rand", $urandom_range(3) != 0, $urandom_range(4) == 0, b, d,
                    $urandom_range(2) != 0);
    end
    applyStimulus("rand_drain1", 0, 0, '0, '0, 1);
    applyStimulus("rand_drain2", 0, 0, '0, '0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
